// File: rtl/spi_xfer_arb.sv
// Round-robin arbiter that shares one SPI engine between NREQ requesters.
// It grants one command at a time, drives the engine control fields and returns read data and status.
module spi_xfer_arb #(
  parameter int NREQ     = 4,
  parameter int WDOG_CYC = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_vld,
  input  logic [2*NREQ-1:0]   req_slv,
  input  logic [4*NREQ-1:0]   req_wlen,
  input  logic [4*NREQ-1:0]   req_rlen,
  input  logic [32*NREQ-1:0]  req_wdata,
  output logic [NREQ-1:0]     req_gnt,
  output logic [NREQ-1:0]     req_wd_ack,
  output logic [NREQ-1:0]     req_rd_vld,
  output logic [31:0]         req_rdata,
  output logic [NREQ-1:0]     req_done,
  output logic [3:0]          req_sts,
  output logic                spi_strt,
  output logic                spi_rdata_en,
  output logic                spi_wd_lst,
  output logic                spi_wd_empty,
  output logic                spi_rd_lst,
  output logic                spi_rd_inf_empty,
  output logic                spi_rd_rdy,
  output logic [1:0]          spi_slv_sel,
  output logic [1:0]          spi_wd_len,
  output logic [1:0]          spi_rd_len,
  output logic [31:0]         spi_rwdata,
  input  logic                spi_done,
  input  logic                spi_wd_r,
  input  logic                spi_rd_inf_r,
  input  logic                spi_rd_ind,
  input  logic                spi_wdat_timeout,
  input  logic                spi_rd_inf_timeout,
  input  logic                spi_rdat_timeout,
  input  logic [31:0]         spi_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(WDOG_CYC);

  typedef enum logic [1:0] {S_IDLE, S_START, S_XFER, S_CPL} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     gidx_q;
  logic [NREQ-1:0]   gnt_q;
  logic [1:0]        slv_q;
  logic [3:0]        wcnt_q, icnt_q, rcnt_q;
  logic              rd_en_q;
  logic              zero_q;
  logic [3:0]        sts_q;
  logic [WW-1:0]     wdog_q;
  logic [NREQ-1:0]   rd_vld_q;
  logic [31:0]       rdata_q;

  logic [1:0]        slv_a   [NREQ];
  logic [3:0]        wlen_a  [NREQ];
  logic [3:0]        rlen_a  [NREQ];
  logic [31:0]       wdata_a [NREQ];

  logic [PW:0]       cand;
  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic              in_xfer;
  logic              wdog_hit;
  logic              busy;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      slv_a[i]   = req_slv[2*i +: 2];
      wlen_a[i]  = req_wlen[4*i +: 4];
      rlen_a[i]  = req_rlen[4*i +: 4];
      wdata_a[i] = req_wdata[32*i +: 32];
    end
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!win_found && req_vld[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  assign in_xfer  = (state_q == S_XFER);
  assign wdog_hit = in_xfer && (wdog_q == WW'(WDOG_CYC - 1));
  assign busy     = |gnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (win_found) state_d = S_START;
      // A zero-length command is granted but bypasses the engine entirely.
      S_START: state_d = zero_q ? S_CPL : S_XFER;
      S_XFER:  if (spi_done || wdog_hit) state_d = S_CPL;
      S_CPL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= PW'(NREQ - 1);
      gidx_q   <= '0;
      gnt_q    <= '0;
      slv_q    <= '0;
      wcnt_q   <= '0;
      icnt_q   <= '0;
      rcnt_q   <= '0;
      rd_en_q  <= 1'b0;
      zero_q   <= 1'b0;
      sts_q    <= '0;
      wdog_q   <= '0;
      rd_vld_q <= '0;
      rdata_q  <= '0;
    end else begin
      rd_vld_q <= (in_xfer && spi_rd_ind) ? gnt_q : '0;
      if (in_xfer && spi_rd_ind) rdata_q <= spi_rdata;

      unique case (state_q)
        S_IDLE: if (win_found) begin
          gnt_q   <= NREQ'(1) << win_idx;
          gidx_q  <= win_idx;
          ptr_q   <= win_idx;
          slv_q   <= slv_a[win_idx];
          wcnt_q  <= wlen_a[win_idx];
          icnt_q  <= rlen_a[win_idx];
          rcnt_q  <= rlen_a[win_idx];
          rd_en_q <= (rlen_a[win_idx] != 4'd0);
          zero_q  <= (wlen_a[win_idx] == 4'd0) && (rlen_a[win_idx] == 4'd0);
          sts_q   <= '0;
        end
        S_START: begin
          sts_q  <= '0;
          wdog_q <= '0;
        end
        S_XFER: begin
          if (spi_wd_r     && wcnt_q != 4'd0) wcnt_q <= wcnt_q - 4'd1;
          if (spi_rd_inf_r && icnt_q != 4'd0) icnt_q <= icnt_q - 4'd1;
          if (spi_rd_ind   && rcnt_q != 4'd0) rcnt_q <= rcnt_q - 4'd1;
          wdog_q <= wdog_q + 1'b1;
          sts_q  <= sts_q | {wdog_hit, spi_rdat_timeout, spi_rd_inf_timeout, spi_wdat_timeout};
        end
        S_CPL:   gnt_q <= '0;
        default: gnt_q <= '0;
      endcase
    end
  end

  always_comb begin
    req_gnt          = gnt_q;
    req_wd_ack       = (in_xfer && spi_wd_r) ? gnt_q : '0;
    req_rd_vld       = rd_vld_q;
    req_rdata        = rdata_q;
    req_done         = (state_q == S_CPL) ? gnt_q : '0;
    req_sts          = (state_q == S_CPL) ? sts_q : '0;
    spi_strt         = (state_q == S_START) && !zero_q;
    spi_wd_len       = 2'b11;
    spi_rd_len       = 2'b11;
    spi_slv_sel      = '0;
    spi_rwdata       = '0;
    spi_wd_empty     = 1'b0;
    spi_wd_lst       = 1'b0;
    spi_rd_inf_empty = 1'b0;
    spi_rd_lst       = 1'b0;
    spi_rd_rdy       = 1'b0;
    spi_rdata_en     = 1'b0;
    if (busy) begin
      spi_slv_sel      = slv_q;
      spi_rwdata       = wdata_a[gidx_q];
      spi_wd_empty     = (wcnt_q == 4'd0);
      spi_wd_lst       = (wcnt_q == 4'd1);
      spi_rd_inf_empty = (icnt_q == 4'd0);
      spi_rd_lst       = (icnt_q == 4'd1);
      spi_rd_rdy       = (rcnt_q != 4'd0);
      spi_rdata_en     = rd_en_q;
    end
  end

endmodule

// File: tb/tb_spi_xfer_arb.sv
// Self-checking bench for spi_xfer_arb: a cycle table for a write transaction,
// then directed sequences for reads, round-robin order, faults, watchdog, zero-length and reset.
module tb_spi_xfer_arb;

  localparam int NREQ     = 4;
  localparam int WDOG_CYC = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req_vld = '0;
  logic [2*NREQ-1:0]  req_slv = '0;
  logic [4*NREQ-1:0]  req_wlen = '0;
  logic [4*NREQ-1:0]  req_rlen = '0;
  logic [32*NREQ-1:0] req_wdata = '0;
  logic [NREQ-1:0]    req_gnt, req_wd_ack, req_rd_vld, req_done;
  logic [31:0]        req_rdata;
  logic [3:0]         req_sts;
  logic               spi_strt, spi_rdata_en, spi_wd_lst, spi_wd_empty;
  logic               spi_rd_lst, spi_rd_inf_empty, spi_rd_rdy;
  logic [1:0]         spi_slv_sel, spi_wd_len, spi_rd_len;
  logic [31:0]        spi_rwdata;
  logic               spi_done = 1'b0, spi_wd_r = 1'b0, spi_rd_inf_r = 1'b0, spi_rd_ind = 1'b0;
  logic               spi_wdat_timeout = 1'b0, spi_rd_inf_timeout = 1'b0, spi_rdat_timeout = 1'b0;
  logic [31:0]        spi_rdata = '0;

  spi_xfer_arb #(.NREQ(NREQ), .WDOG_CYC(WDOG_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_slv(req_slv), .req_wlen(req_wlen), .req_rlen(req_rlen),
    .req_wdata(req_wdata), .req_gnt(req_gnt), .req_wd_ack(req_wd_ack),
    .req_rd_vld(req_rd_vld), .req_rdata(req_rdata), .req_done(req_done), .req_sts(req_sts),
    .spi_strt(spi_strt), .spi_rdata_en(spi_rdata_en), .spi_wd_lst(spi_wd_lst),
    .spi_wd_empty(spi_wd_empty), .spi_rd_lst(spi_rd_lst), .spi_rd_inf_empty(spi_rd_inf_empty),
    .spi_rd_rdy(spi_rd_rdy), .spi_slv_sel(spi_slv_sel), .spi_wd_len(spi_wd_len),
    .spi_rd_len(spi_rd_len), .spi_rwdata(spi_rwdata), .spi_done(spi_done),
    .spi_wd_r(spi_wd_r), .spi_rd_inf_r(spi_rd_inf_r), .spi_rd_ind(spi_rd_ind),
    .spi_wdat_timeout(spi_wdat_timeout), .spi_rd_inf_timeout(spi_rd_inf_timeout),
    .spi_rdat_timeout(spi_rdat_timeout), .spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] vld;
    logic       wd_r;
    logic       dn;
    logic [3:0] e_gnt;
    logic       e_strt;
    logic [3:0] e_ack;
    logic       e_lst;
    logic       e_emp;
    logic [3:0] e_done;
    logic [1:0] e_slv;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_cmd(input int r, input logic [1:0] slv, input logic [3:0] wl,
                         input logic [3:0] rl, input logic [31:0] wd);
    req_slv[2*r +: 2]    = slv;
    req_wlen[4*r +: 4]   = wl;
    req_rlen[4*r +: 4]   = rl;
    req_wdata[32*r +: 32] = wd;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, req_gnt, 0);
    check({tag, "_ack"}, req_wd_ack, 0);
    check({tag, "_done_sts"}, {req_done, req_sts}, 0);
    check({tag, "_rd"}, {req_rd_vld, req_rdata}, 0);
    check({tag, "_ctrl"}, {spi_strt, spi_rdata_en, spi_wd_lst, spi_wd_empty,
                           spi_rd_lst, spi_rd_inf_empty, spi_rd_rdy}, 0);
    check({tag, "_sel_wd"}, {spi_slv_sel, spi_rwdata}, 0);
    check({tag, "_lens"}, {spi_wd_len, spi_rd_len}, 4'b1111);
  endtask

  function automatic vec_t mkv(input logic [3:0] vld, input logic wd_r, input logic dn,
                               input logic [3:0] e_gnt, input logic e_strt, input logic [3:0] e_ack,
                               input logic e_lst, input logic e_emp, input logic [3:0] e_done,
                               input logic [1:0] e_slv);
    vec_t v;
    v.vld = vld; v.wd_r = wd_r; v.dn = dn; v.e_gnt = e_gnt; v.e_strt = e_strt;
    v.e_ack = e_ack; v.e_lst = e_lst; v.e_emp = e_emp; v.e_done = e_done; v.e_slv = e_slv;
    return v;
  endfunction

  initial begin
    logic [3:0] exp_g;

    // Write transaction on r0: slv=2, wlen=3, rlen=0; one row per clock cycle.
    //                 vld      wd dn  gnt     strt ack     lst emp done    slv
    vecs[0] = mkv(4'b0001, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 2'd0); // IDLE samples vld
    vecs[1] = mkv(4'b0001, 0, 0, 4'b0001, 1, 4'b0000, 0, 0, 4'b0000, 2'd2); // START
    vecs[2] = mkv(4'b0001, 1, 0, 4'b0001, 0, 4'b0001, 0, 0, 4'b0000, 2'd2); // wcnt=3, ack 1
    vecs[3] = mkv(4'b0001, 1, 0, 4'b0001, 0, 4'b0001, 0, 0, 4'b0000, 2'd2); // wcnt=2, ack 2
    vecs[4] = mkv(4'b0001, 0, 0, 4'b0001, 0, 4'b0000, 1, 0, 4'b0000, 2'd2); // wcnt=1 -> lst
    vecs[5] = mkv(4'b0001, 1, 0, 4'b0001, 0, 4'b0001, 1, 0, 4'b0000, 2'd2); // ack 3
    vecs[6] = mkv(4'b0001, 0, 1, 4'b0001, 0, 4'b0000, 0, 1, 4'b0000, 2'd2); // wcnt=0, spi_done
    vecs[7] = mkv(4'b0001, 0, 0, 4'b0001, 0, 4'b0000, 0, 1, 4'b0001, 2'd2); // CPL
    vecs[8] = mkv(4'b0000, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 4'b0000, 2'd0); // back to IDLE

    #2;
    check_quiet("reset");
    step();
    step();
    rst_n = 1'b1;
    step();

    set_cmd(0, 2'd2, 4'd3, 4'd0, 32'hA0A0_0001);
    for (int i = 0; i < 9; i++) begin
      req_vld  = vecs[i].vld;
      spi_wd_r = vecs[i].wd_r;
      spi_done = vecs[i].dn;
      settle();
      check($sformatf("wr%0d_gnt", i),  req_gnt,      vecs[i].e_gnt);
      check($sformatf("wr%0d_strt", i), spi_strt,     vecs[i].e_strt);
      check($sformatf("wr%0d_ack", i),  req_wd_ack,   vecs[i].e_ack);
      check($sformatf("wr%0d_lst", i),  spi_wd_lst,   vecs[i].e_lst);
      check($sformatf("wr%0d_emp", i),  spi_wd_empty, vecs[i].e_emp);
      check($sformatf("wr%0d_done", i), req_done,     vecs[i].e_done);
      check($sformatf("wr%0d_sts", i),  req_sts,      4'b0000);
      check($sformatf("wr%0d_slv", i),  spi_slv_sel,  vecs[i].e_slv);
      step();
    end
    spi_wd_r = 1'b0;
    spi_done = 1'b0;

    // Read on r1: second word coincides with spi_done.
    set_cmd(1, 2'd1, 4'd1, 4'd2, 32'h1111_2222);
    req_vld = 4'b0010;
    settle();
    step();
    settle();
    check("rd_gnt", req_gnt, 4'b0010);
    check("rd_strt", spi_strt, 1'b1);
    check("rd_en_rdy", {spi_rdata_en, spi_rd_rdy, spi_rd_lst, spi_rd_inf_empty}, 4'b1100);
    step();
    spi_wd_r = 1'b1;
    settle();
    check("rd_wack", req_wd_ack, 4'b0010);
    check("rd_rwdata", spi_rwdata, 32'h1111_2222);
    step();
    spi_wd_r   = 1'b0;
    spi_rd_ind = 1'b1;
    spi_rdata  = 32'hDEAD_BEEF;
    settle();
    check("rd_vld_early", req_rd_vld, 4'b0000);
    step();
    spi_rdata = 32'h1234_5678;
    spi_done  = 1'b1;
    settle();
    check("rd_w1_vld", req_rd_vld, 4'b0010);
    check("rd_w1_data", req_rdata, 32'hDEAD_BEEF);
    check("rd_rdy_mid", spi_rd_rdy, 1'b1);
    step();
    spi_rd_ind = 1'b0;
    spi_done   = 1'b0;
    settle();
    check("rd_w2_vld", req_rd_vld, 4'b0010);
    check("rd_w2_data", req_rdata, 32'h1234_5678);
    check("rd_done", req_done, 4'b0010);
    check("rd_sts", req_sts, 4'b0000);
    check("rd_rdy_end", spi_rd_rdy, 1'b0);
    req_vld = 4'b0000;
    step();
    settle();
    check("rd_after", {req_rd_vld, req_gnt}, 8'h00);

    // Round-robin from reset: pointer restarts so r0 wins first.
    rst_n = 1'b0;
    settle();
    rst_n = 1'b1;
    step();
    for (int r = 0; r < NREQ; r++) set_cmd(r, 2'(r), 4'd1, 4'd0, 32'h5000_0000 + 32'(r));
    req_vld = 4'b1111;
    settle();
    step();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      settle();
      check($sformatf("rr%0d_gnt", k), req_gnt, exp_g);
      check($sformatf("rr%0d_strt", k), spi_strt, 1'b1);
      step();
      spi_done = 1'b1;
      settle();
      check($sformatf("rr%0d_nodone", k), req_done, 4'b0000);
      step();
      spi_done = 1'b0;
      if (k == 4) req_vld = 4'b0000;
      settle();
      check($sformatf("rr%0d_done", k), req_done, exp_g);
      step();
      settle();
      check($sformatf("rr%0d_gap", k), req_gnt, 4'b0000);
      step();
    end

    // Read-data timeout on r3 while info counter runs down.
    set_cmd(3, 2'd3, 4'd2, 4'd1, 32'hCAFE_0003);
    req_vld = 4'b1000;
    settle();
    step();
    settle();
    check("flt_gnt", req_gnt, 4'b1000);
    check("flt_sel_lst", {spi_slv_sel, spi_rd_lst}, 3'b111);
    step();
    spi_rdat_timeout = 1'b1;
    spi_rd_inf_r     = 1'b1;
    settle();
    check("flt_sts_hidden", req_sts, 4'b0000);
    step();
    spi_rdat_timeout = 1'b0;
    spi_rd_inf_r     = 1'b0;
    settle();
    check("flt_inf_empty", {spi_rd_inf_empty, spi_rd_lst}, 2'b10);
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    req_vld  = 4'b0000;
    settle();
    check("flt_done", req_done, 4'b1000);
    check("flt_sts", req_sts, 4'b0100);
    step();

    // Watchdog: no spi_done; done lands WDOG_CYC cycles after XFER entry.
    set_cmd(0, 2'd0, 4'd1, 4'd0, 32'h0);
    req_vld = 4'b0001;
    settle();
    step();
    step();
    for (int n = 0; n < WDOG_CYC; n++) begin
      settle();
      check($sformatf("wdog_wait%0d", n), req_done, 4'b0000);
      step();
    end
    settle();
    check("wdog_done", req_done, 4'b0001);
    check("wdog_sts", req_sts, 4'b1000);
    req_vld = 4'b0000;
    step();

    // Zero-length command on r2.
    set_cmd(2, 2'd1, 4'd0, 4'd0, 32'h0);
    req_vld = 4'b0100;
    settle();
    step();
    settle();
    check("zl_gnt", req_gnt, 4'b0100);
    check("zl_nostrt1", spi_strt, 1'b0);
    step();
    settle();
    check("zl_done", req_done, 4'b0100);
    check("zl_sts", req_sts, 4'b0000);
    check("zl_nostrt2", spi_strt, 1'b0);
    req_vld = 4'b0000;
    step();

    // Reset during XFER: outputs drop at once, no completion follows.
    set_cmd(1, 2'd2, 4'd2, 4'd2, 32'h7777_0001);
    req_vld = 4'b0010;
    settle();
    step();
    step();
    spi_wd_r = 1'b1;
    settle();
    check("mr_ack", req_wd_ack, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("mr");
    spi_wd_r = 1'b0;
    req_vld  = 4'b0000;
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      check($sformatf("mr_post%0d", n), {req_done, req_gnt}, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
